// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode/direction encodings and duty-slice helper for pwm_multi_ch
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  localparam int VEC_MAX_W   = 1024;
  localparam int SLICE_MAX_W = 32;

  // Channel ch occupies bits [ch*width +: width] of the packed duty bus.
  function automatic logic [SLICE_MAX_W-1:0] duty_slice(input logic [VEC_MAX_W-1:0] vec,
                                                        input int width, input int ch);
    logic [VEC_MAX_W-1:0] mask;
    mask = {VEC_MAX_W{1'b1}} >> (VEC_MAX_W - width);
    return SLICE_MAX_W'((vec >> (ch * width)) & mask);
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - per-channel break-before-make complementary driver (PWM_DEADTIME_EN builds)
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                syn_rst,
  input  logic                en,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                p,
  output logic                n
);

  logic                raw_q, p_q, n_q;
  logic [DT_WIDTH-1:0] run_q, run_d, run_now;

  // run_now = clocks raw has held its current level before this one; saturates.
  assign run_now = (raw != raw_q) ? '0 : run_q;
  assign run_d   = (run_now == '1) ? run_now : run_now + DT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      raw_q <= 1'b0;
      run_q <= '0;
      p_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      raw_q <= raw;
      run_q <= run_d;
      p_q   <= en & raw & (run_now >= dead_time);
      n_q   <= en & ~raw & (run_now >= dead_time);
    end
  end

  assign p = p_q;
  assign n = n_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - shared-counter multi-channel PWM with double-buffered config
// PWM_DEADTIME_EN adds dead_time / pwm_out_n via per-channel pwm_deadtime instances.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_CH    = 4
`ifdef PWM_DEADTIME_EN
  , parameter int DT_WIDTH = 8
`endif
) (
  input  logic                        clk,
  input  logic                        syn_rst,
  input  logic                        en,
  input  logic                        cfg_we,
  input  logic [PWM_WIDTH-1:0]        cfg_period,
  input  logic [NUM_CH*PWM_WIDTH-1:0] cfg_duty,
  input  logic                        cfg_center,
`ifdef PWM_DEADTIME_EN
  input  logic [DT_WIDTH-1:0]         dead_time,
  output logic [NUM_CH-1:0]           pwm_out_n,
`endif
  output logic                        upd_done,
  output logic                        sync_out,
  output logic [NUM_CH-1:0]           pwm_out
);

  typedef logic [PWM_WIDTH-1:0] word_t;

  word_t             per_q, per_s_q, per_n, cnt_q, cnt_d;
  word_t             duty_q   [NUM_CH];
  word_t             duty_s_q [NUM_CH];
  word_t             duty_in  [NUM_CH];
  logic              mode_q, mode_s_q, mode_n, dir_q, dir_d;
  logic              pend_q, upd_q, sync_q;
  logic              bnd, apply, center_up;
  logic [NUM_CH-1:0] raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
    assign duty_in[i] = PWM_WIDTH'(duty_slice(VEC_MAX_W'(cfg_duty), PWM_WIDTH, i));
  end

  // en=0 counts as a boundary so pending updates still land while stopped.
  assign bnd = !en || (per_q == '0) ||
               ((mode_q == MODE_EDGE) ? (cnt_q >= per_q)
                                      : ((cnt_q == '0) && (dir_q == DIR_DOWN)));
  assign apply  = bnd & pend_q;
  assign per_n  = apply ? per_s_q : per_q;
  assign mode_n = apply ? mode_s_q : mode_q;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (bnd) begin
      // The centre valley is already cnt=0, so the next period resumes at 1.
      dir_d = DIR_UP;
      cnt_d = ((cnt_q == '0) && (per_n != '0) && (mode_n == MODE_CENTER)) ? word_t'(1) : '0;
    end else if (mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + word_t'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_q) begin
        dir_d = DIR_DOWN;
        cnt_d = cnt_q - word_t'(1);
      end else begin
        cnt_d = cnt_q + word_t'(1);
      end
    end else begin
      cnt_d = cnt_q - word_t'(1);
    end
  end

  // Inclusive compare on the up-slope gives exactly 2*duty high clocks per centre period.
  assign center_up = (mode_q == MODE_CENTER) && (dir_q == DIR_UP);

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = en & ((cnt_q < duty_q[i]) |
                     (center_up & (cnt_q == duty_q[i]) & (duty_q[i] != '0)));
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      per_q    <= '0;
      per_s_q  <= '0;
      mode_q   <= MODE_EDGE;
      mode_s_q <= MODE_EDGE;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      pend_q   <= 1'b0;
      upd_q    <= 1'b0;
      sync_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]   <= '0;
        duty_s_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      pend_q <= cfg_we | (pend_q & ~apply);
      upd_q  <= apply;
      sync_q <= en & bnd;
      if (apply) begin
        per_q  <= per_s_q;
        mode_q <= mode_s_q;
        duty_q <= duty_s_q;
      end
      if (cfg_we) begin
        per_s_q  <= cfg_period;
        mode_s_q <= cfg_center;
        duty_s_q <= duty_in;
      end
    end
  end

  assign upd_done = upd_q;
  assign sync_out = sync_q;

`ifdef PWM_DEADTIME_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_dt
    pwm_deadtime #(.DT_WIDTH(DT_WIDTH)) u_dt (
      .clk       (clk),
      .syn_rst   (syn_rst),
      .en        (en),
      .raw       (raw[i]),
      .dead_time (dead_time),
      .p         (pwm_out[i]),
      .n         (pwm_out_n[i])
    );
  end
`else
  logic [NUM_CH-1:0] pwm_q;

  always_ff @(posedge clk) begin
    if (syn_rst) pwm_q <= '0;
    else         pwm_q <= raw;
  end

  assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - scoreboard bench for pwm_multi_ch (PWM_WIDTH=8, NUM_CH=2)
module tb_pwm_multi_ch;

  localparam int W = 8;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         syn_rst, en, cfg_we, cfg_center;
  logic [W-1:0] cfg_period;
  logic [N*W-1:0] cfg_duty;
  logic         upd_done, sync_out;
  logic [N-1:0] pwm_out;
`ifdef PWM_DEADTIME_EN
  logic [7:0]   dead_time;
  logic [N-1:0] pwm_out_n;
`endif

  pwm_multi_ch #(.PWM_WIDTH(W), .NUM_CH(N)) dut (
    .clk        (clk),
    .syn_rst    (syn_rst),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_center (cfg_center),
`ifdef PWM_DEADTIME_EN
    .dead_time  (dead_time),
    .pwm_out_n  (pwm_out_n),
`endif
    .upd_done   (upd_done),
    .sync_out   (sync_out),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    int    h0;
    int    h1;
    int    upd;
    int    n0;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  task automatic push(input string name, input int len, input int h0, input int h1,
                      input int upd, input int n0);
    exp_t e;
    e.name = name; e.len = len; e.h0 = h0; e.h1 = h1; e.upd = upd; e.n0 = n0;
    exp_q.push_back(e);
  endtask

  // Monitor: one window per sync_out pulse, compared against the head of the queue.
  initial begin : monitor
    int   len, h0, h1, upd, n0, both;
    exp_t e;
    len = 0; h0 = 0; h1 = 0; upd = 0; n0 = 0; both = 0;
    forever begin
      @(negedge clk);
      if (sync_out === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({e.name, ".len"}, len, e.len);
          chk({e.name, ".ch0_high"}, h0, e.h0);
          chk({e.name, ".ch1_high"}, h1, e.h1);
          chk({e.name, ".upd_done"}, upd, e.upd);
`ifdef PWM_DEADTIME_EN
          if (e.n0 >= 0) chk({e.name, ".ch0_n_high"}, n0, e.n0);
          chk({e.name, ".overlap"}, both, 0);
`endif
        end
        len = 0; h0 = 0; h1 = 0; upd = 0; n0 = 0; both = 0;
      end
      len++;
      h0  += int'(pwm_out[0] === 1'b1);
      h1  += int'(pwm_out[1] === 1'b1);
      upd += int'(upd_done === 1'b1);
`ifdef PWM_DEADTIME_EN
      n0   += int'(pwm_out_n[0] === 1'b1);
      both += int'((pwm_out & pwm_out_n) != '0);
`endif
    end
  end

  task automatic wait_sync();
    int k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (sync_out !== 1'b1 && k < 300);
    if (sync_out !== 1'b1) chk("wait_sync_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 600) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1, input logic c);
    cfg_period = W'(p);
    cfg_duty   = {W'(d1), W'(d0)};
    cfg_center = c;
    cfg_we     = 1'b1;
    @(negedge clk); #1;
    cfg_we     = 1'b0;
  endtask

  task automatic settle();
    wait_sync();
    wait_sync();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int s, u, k;
    syn_rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_center = 1'b0;
    cfg_period = '0; cfg_duty = '0;
`ifdef PWM_DEADTIME_EN
    dead_time = 8'd0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset.pwm_out", int'(pwm_out), 0);
    chk("reset.sync_out", int'(sync_out), 0);
    chk("reset.upd_done", int'(upd_done), 0);
    syn_rst = 1'b0;
    en      = 1'b1;

    // P=0 after reset: every cycle is a boundary, outputs low
    wait_sync();
    for (int i = 0; i < 3; i++) push("p0", 1, 0, 0, 0, -1);
    wait_drain();

    // edge P=9, ch0=3, ch1=0
    set_cfg(9, 3, 0, 1'b0);
    settle();
    for (int i = 0; i < 3; i++) push("edge_d3", 10, 3, 0, 0, -1);
    wait_drain();

    // duty beyond P -> constant high, then duty 0 -> constant low
    set_cfg(9, 10, 255, 1'b0);
    settle();
    for (int i = 0; i < 2; i++) push("edge_full", 10, 10, 10, 0, -1);
    wait_drain();
    set_cfg(9, 0, 0, 1'b0);
    settle();
    for (int i = 0; i < 2; i++) push("edge_zero", 10, 0, 0, 0, -1);
    wait_drain();

    // centre P=4: ch0=2 -> 4 of 8, ch1=5 (>P) -> constant high
    set_cfg(4, 2, 5, 1'b1);
    settle();
    for (int i = 0; i < 2; i++) push("centre", 8, 4, 8, 0, -1);
    wait_drain();

    // staged update mid-period, last write wins
    set_cfg(9, 3, 0, 1'b0);
    settle();
    wait_sync();
    push("upd_old", 10, 3, 0, 0, -1);
    push("upd_new", 10, 6, 0, 1, -1);
    push("upd_hold", 10, 6, 0, 0, -1);
    repeat (2) @(negedge clk);
    set_cfg(9, 7, 0, 1'b0);
    repeat (2) @(negedge clk);
    set_cfg(9, 6, 0, 1'b0);
    wait_drain();

    // write at cnt=3 applies at next boundary; write on the boundary itself is deferred
    wait_sync();
    push("defer_a", 10, 6, 0, 0, -1);
    push("defer_b", 10, 2, 0, 1, -1);
    push("defer_c", 10, 8, 0, 1, -1);
    push("defer_d", 10, 8, 0, 0, -1);
    repeat (3) @(negedge clk);
    set_cfg(9, 2, 0, 1'b0);
    repeat (5) @(negedge clk);
    set_cfg(9, 8, 0, 1'b0);
    wait_drain();

    // syn_rst at cnt=4 with an update pending
    wait_sync();
    repeat (2) @(negedge clk);
    set_cfg(9, 6, 0, 1'b0);
    @(negedge clk);
    chk("pre_rst.pwm_out", int'(pwm_out), 1);
    syn_rst = 1'b1;
    @(negedge clk); #1;
    chk("rst.pwm_out", int'(pwm_out), 0);
    chk("rst.sync_out", int'(sync_out), 0);
    chk("rst.upd_done", int'(upd_done), 0);
    @(negedge clk); #1;
    syn_rst = 1'b0;
    wait_sync();
    for (int i = 0; i < 4; i++) push("post_rst", 1, 0, 0, 0, -1);
    wait_drain();

    // en=0 mid-period, pending update applied while stopped, restart from cnt=0
    set_cfg(9, 6, 255, 1'b0);
    settle();
    wait_sync();
    repeat (3) @(negedge clk);
    chk("pre_en0.pwm_out", int'(pwm_out), 3);
    en = 1'b0;
    @(negedge clk); #1;
    chk("en0.pwm_out", int'(pwm_out), 0);
    cfg_period = W'(9);
    cfg_duty   = {W'(255), W'(2)};
    cfg_center = 1'b0;
    cfg_we     = 1'b1;
    s = 0; u = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      cfg_we = 1'b0;
      s += int'(sync_out);
      u += int'(upd_done);
    end
    chk("en0.sync_count", s, 0);
    chk("en0.upd_count", u, 1);
    en = 1'b1;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
      if (k == 1) chk("reen.first_pwm", int'(pwm_out), 3);
    end while (sync_out !== 1'b1 && k < 40);
    chk("reen.first_sync_delay", k, 10);
    for (int i = 0; i < 2; i++) push("reen", 10, 2, 10, 0, -1);
    wait_drain();

`ifdef PWM_DEADTIME_EN
    dead_time = 8'd2;
    set_cfg(9, 5, 0, 1'b0);
    settle();
    for (int i = 0; i < 2; i++) push("dt_d5", 10, 3, 0, 0, 3);
    wait_drain();
    set_cfg(9, 1, 0, 1'b0);
    settle();
    for (int i = 0; i < 2; i++) push("dt_d1", 10, 0, 0, 0, 7);
    wait_drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
